// File: rtl/tcu_csr_arb.sv
// -----------------------------------------------------------------------------
// tcu_csr_arb
//
// Shares the single tensor-core-to-CSR access port between NUM_REQS requesters.
// A round-robin arbiter grants one requester per cycle. Each accepted request is
// turned into one registered CSR read or write strobe in the following cycle.
// Read data returns two cycles after acceptance, tagged with the requester index.
//
// Optional feature macro: TCU_CSR_ARB_LOCK_EN
//   When defined, a handshake with req_lock=1 makes that requester the lock
//   owner. Only the owner can then be granted, even while it is idle. The
//   owner's first handshake with req_lock=0 releases the lock after that access.
//   When undefined, req_lock is ignored and no lock state is built.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   req_valid/rw/lock  : per-requester request valid, 1=write/0=read, lock hold
//   req_addr           : packed addresses, requester i at [i*ADDR_BITS +: ADDR_BITS]
//   req_wdata          : packed write data, 32 bits per requester
//   req_ready          : one-hot combinational grant
//   rsp_valid/idx      : read response valid and issuing requester index
//   rsp_data_a/b       : read data, passed through from the CSR unit
//   csr_write_*        : registered write strobe, address, data
//   csr_read_*         : registered read strobe, address
//   csr_read_data_a/b  : CSR read data, valid one cycle after csr_read_enable
// -----------------------------------------------------------------------------
`ifndef VX_CSR_ADDR_BITS
`define VX_CSR_ADDR_BITS 12
`endif

module tcu_csr_arb #(
    parameter int NUM_REQS  = 4,
    parameter int ADDR_BITS = `VX_CSR_ADDR_BITS,
    localparam int REQ_SEL_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS-1:0]           req_rw,
    input  logic [NUM_REQS-1:0]           req_lock,
    input  logic [NUM_REQS*ADDR_BITS-1:0] req_addr,
    input  logic [NUM_REQS*32-1:0]        req_wdata,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic                          rsp_valid,
    output logic [REQ_SEL_BITS-1:0]       rsp_idx,
    output logic [31:0]                   rsp_data_a,
    output logic [31:0]                   rsp_data_b,
    output logic                          csr_write_enable,
    output logic [31:0]                   csr_write_data,
    output logic [ADDR_BITS-1:0]          csr_write_addr,
    output logic                          csr_read_enable,
    output logic [ADDR_BITS-1:0]          csr_read_addr,
    input  logic [31:0]                   csr_read_data_a,
    input  logic [31:0]                   csr_read_data_b
);

    // Arbitration state and issue/response pipeline registers
    logic [REQ_SEL_BITS-1:0] rr_ptr_q,    rr_ptr_d;
    logic                    wr_en_q,     wr_en_d;
    logic                    rd_en_q,     rd_en_d;
    logic [ADDR_BITS-1:0]    wr_addr_q,   wr_addr_d;
    logic [31:0]             wr_data_q,   wr_data_d;
    logic [ADDR_BITS-1:0]    rd_addr_q,   rd_addr_d;
    logic [REQ_SEL_BITS-1:0] rd_idx_q,    rd_idx_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [REQ_SEL_BITS-1:0] rsp_idx_q,   rsp_idx_d;

    // Grant and selected-request signals
    logic [NUM_REQS-1:0]     grant_s;
    logic [REQ_SEL_BITS-1:0] grant_idx_s;
    logic                    found_s;
    logic                    hs_s;
    logic                    sel_rw_s;
    logic [ADDR_BITS-1:0]    sel_addr_s;
    logic [31:0]             sel_wdata_s;

`ifdef TCU_CSR_ARB_LOCK_EN
    logic                    lock_held_q,  lock_held_d;
    logic [REQ_SEL_BITS-1:0] lock_owner_q, lock_owner_d;
    logic                    sel_lock_s;
`else
    logic                    unused_lock_s;
    assign unused_lock_s = ^req_lock;
`endif

    // Grant selection: owner-only while locked, otherwise round-robin from rr_ptr_q.
    // The round-robin search runs as two passes (ptr..N-1, then 0..ptr-1) so every
    // index into req_valid is a loop constant.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        found_s     = 1'b0;
        if (reset) begin
            grant_s = '0;
        end
`ifdef TCU_CSR_ARB_LOCK_EN
        else if (lock_held_q) begin
            if (req_valid[lock_owner_q]) begin
                grant_s[lock_owner_q] = 1'b1;
                grant_idx_s           = lock_owner_q;
            end else begin
                grant_s = '0;
            end
        end
`endif
        else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!found_s && req_valid[i] && (i >= int'(rr_ptr_q))) begin
                    found_s     = 1'b1;
                    grant_s[i]  = 1'b1;
                    grant_idx_s = REQ_SEL_BITS'(i);
                end else begin
                    found_s = found_s;
                end
            end
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!found_s && req_valid[i] && (i < int'(rr_ptr_q))) begin
                    found_s     = 1'b1;
                    grant_s[i]  = 1'b1;
                    grant_idx_s = REQ_SEL_BITS'(i);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    assign hs_s = |grant_s;

    // One-hot AND-OR mux of the granted request's fields
    always_comb begin
        sel_rw_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = 32'h0000_0000;
`ifdef TCU_CSR_ARB_LOCK_EN
        sel_lock_s  = 1'b0;
`endif
        for (int i = 0; i < NUM_REQS; i++) begin
            sel_rw_s    = sel_rw_s | (grant_s[i] & req_rw[i]);
            sel_addr_s  = sel_addr_s  | ({ADDR_BITS{grant_s[i]}} & req_addr[i*ADDR_BITS +: ADDR_BITS]);
            sel_wdata_s = sel_wdata_s | ({32{grant_s[i]}} & req_wdata[i*32 +: 32]);
`ifdef TCU_CSR_ARB_LOCK_EN
            sel_lock_s  = sel_lock_s | (grant_s[i] & req_lock[i]);
`endif
        end
    end

    // Next state of the pointer, the issue stage and the response stage
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        rd_idx_d    = rd_idx_q;
        rsp_valid_d = rd_en_q;
        rsp_idx_d   = rd_idx_q;
        if (hs_s) begin
            if (grant_idx_s == REQ_SEL_BITS'(NUM_REQS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_s + REQ_SEL_BITS'(1);
            end
            if (sel_rw_s) begin
                wr_en_d   = 1'b1;
                wr_addr_d = sel_addr_s;
                wr_data_d = sel_wdata_s;
            end else begin
                rd_en_d   = 1'b1;
                rd_addr_d = sel_addr_s;
                rd_idx_d  = grant_idx_s;
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Pipeline and pointer registers; reset drops any read in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 32'h0000_0000;
            rd_addr_q   <= '0;
            rd_idx_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            rd_idx_q    <= rd_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
        end
    end

`ifdef TCU_CSR_ARB_LOCK_EN
    // Lock ownership: set by a locked handshake, released by the owner's unlocked one.
    // While held only the owner can handshake, so any handshake here is the owner's.
    always_comb begin
        lock_held_d  = lock_held_q;
        lock_owner_d = lock_owner_q;
        if (hs_s) begin
            if (sel_lock_s) begin
                lock_held_d  = 1'b1;
                lock_owner_d = grant_idx_s;
            end else begin
                lock_held_d  = 1'b0;
            end
        end else begin
            lock_held_d = lock_held_q;
        end
    end

    // Lock state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_held_q  <= 1'b0;
            lock_owner_q <= '0;
        end else begin
            lock_held_q  <= lock_held_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`endif

    assign req_ready        = grant_s;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_idx          = rsp_idx_q;
    assign rsp_data_a       = csr_read_data_a;
    assign rsp_data_b       = csr_read_data_b;
    assign csr_write_enable = wr_en_q;
    assign csr_write_data   = wr_data_q;
    assign csr_write_addr   = wr_addr_q;
    assign csr_read_enable  = rd_en_q;
    assign csr_read_addr    = rd_addr_q;

endmodule

// File: tb/tb_tcu_csr_arb.sv
// -----------------------------------------------------------------------------
// tb_tcu_csr_arb
//
// Directed steps from the test plan followed by a randomized phase. A reference
// model predicts grants from the arbitration rules and records, per cycle
// number, which strobes, addresses and responses must appear. The bench also
// plays the CSR unit with a small memory so write-then-read ordering is seen.
// -----------------------------------------------------------------------------
module tb_tcu_csr_arb;

    localparam int N    = 4;
    localparam int AB   = 12;
    localparam int MAXC = 1024;
    localparam logic [31:0] B_XOR = 32'h4444_44CC;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_rw;
    logic [N-1:0]      req_lock;
    logic [N*AB-1:0]   req_addr;
    logic [N*32-1:0]   req_wdata;
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_idx;
    logic [31:0]       rsp_data_a;
    logic [31:0]       rsp_data_b;
    logic              csr_write_enable;
    logic [31:0]       csr_write_data;
    logic [AB-1:0]     csr_write_addr;
    logic              csr_read_enable;
    logic [AB-1:0]     csr_read_addr;
    logic [31:0]       csr_read_data_a;
    logic [31:0]       csr_read_data_b;

    tcu_csr_arb #(.NUM_REQS(N), .ADDR_BITS(AB)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_rw           (req_rw),
        .req_lock         (req_lock),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_idx          (rsp_idx),
        .rsp_data_a       (rsp_data_a),
        .rsp_data_b       (rsp_data_b),
        .csr_write_enable (csr_write_enable),
        .csr_write_data   (csr_write_data),
        .csr_write_addr   (csr_write_addr),
        .csr_read_enable  (csr_read_enable),
        .csr_read_addr    (csr_read_addr),
        .csr_read_data_a  (csr_read_data_a),
        .csr_read_data_b  (csr_read_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    int          m_ptr   = 0;
    bit          m_lock  = 1'b0;
    int          m_owner = 0;
    bit [31:0]   ref_mem [4096];
    bit [31:0]   csr_mem [4096];
    bit          e_wr    [MAXC];
    bit          e_rd    [MAXC];
    bit [AB-1:0] e_wa    [MAXC];
    bit [31:0]   e_wd    [MAXC];
    bit [AB-1:0] e_ra    [MAXC];
    bit          e_rsp   [MAXC];
    int          e_ridx  [MAXC];
    bit [31:0]   e_rdat  [MAXC];

    // CSR responder state
    bit          pend_rd   = 1'b0;
    bit [AB-1:0] pend_addr = '0;
    logic [N-1:0] seen_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Winner under the arbitration rules, or -1 when nobody is granted
    function automatic int model_grant();
        int i;
        if (reset) return -1;
`ifdef TCU_CSR_ARB_LOCK_EN
        if (m_lock) return req_valid[m_owner] ? m_owner : -1;
`endif
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input bit rw, input bit lk,
                           input logic [AB-1:0] a, input logic [31:0] d);
        req_valid[i]          = v;
        req_rw[i]             = rw;
        req_lock[i]           = lk;
        req_addr[i*AB +: AB]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    // One clock cycle: check the grant, advance the model, clock, act as CSR, check outputs
    task automatic step();
        int          g;
        int          nc;
        logic [N-1:0] eg;
        logic [AB-1:0] a;
        #1;
        g  = model_grant();
        eg = (g < 0) ? 4'b0000 : 4'(1 << g);
        seen_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(eg));
        nc = cyc + 1;
        e_wr[nc]    = 1'b0;
        e_rd[nc]    = 1'b0;
        e_wa[nc]    = e_wa[cyc];
        e_wd[nc]    = e_wd[cyc];
        e_ra[nc]    = e_ra[cyc];
        e_rsp[nc+1] = 1'b0;
        if (reset) begin
            m_ptr    = 0;
            m_lock   = 1'b0;
            e_wa[nc] = '0;
            e_wd[nc] = 32'h0;
            e_ra[nc] = '0;
            e_rsp[nc] = 1'b0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N;
`ifdef TCU_CSR_ARB_LOCK_EN
            if (req_lock[g]) begin
                m_lock  = 1'b1;
                m_owner = g;
            end else begin
                m_lock = 1'b0;
            end
`endif
            a = req_addr[g*AB +: AB];
            if (req_rw[g]) begin
                e_wr[nc]   = 1'b1;
                e_wa[nc]   = a;
                e_wd[nc]   = req_wdata[g*32 +: 32];
                ref_mem[a] = req_wdata[g*32 +: 32];
            end else begin
                e_rd[nc]     = 1'b1;
                e_ra[nc]     = a;
                e_rsp[nc+1]  = 1'b1;
                e_ridx[nc+1] = g;
                e_rdat[nc+1] = ref_mem[a];
            end
        end
        @(posedge clk);
        #1;
        cyc = nc;
        if (pend_rd) begin
            csr_read_data_a = csr_mem[pend_addr];
            csr_read_data_b = csr_mem[pend_addr] ^ B_XOR;
        end else begin
            csr_read_data_a = $urandom;
            csr_read_data_b = $urandom;
        end
        pend_rd   = csr_read_enable;
        pend_addr = csr_read_addr;
        if (csr_write_enable) csr_mem[csr_write_addr] = csr_write_data;
        #1;
        chk("wr_en",     64'(csr_write_enable), 64'(e_wr[cyc]));
        chk("rd_en",     64'(csr_read_enable),  64'(e_rd[cyc]));
        chk("wr_addr",   64'(csr_write_addr),   64'(e_wa[cyc]));
        chk("wr_data",   64'(csr_write_data),   64'(e_wd[cyc]));
        chk("rd_addr",   64'(csr_read_addr),    64'(e_ra[cyc]));
        chk("rsp_valid", 64'(rsp_valid),        64'(e_rsp[cyc]));
        if (e_rsp[cyc]) begin
            chk("rsp_idx",    64'(rsp_idx),    64'(e_ridx[cyc]));
            chk("rsp_data_a", 64'(rsp_data_a), 64'(e_rdat[cyc]));
            chk("rsp_data_b", 64'(rsp_data_b), 64'(e_rdat[cyc] ^ B_XOR));
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_rw    = '0;
        req_lock  = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0]  lk_exp [5];
        bit          lk_v   [5];
        bit          lk_l   [5];
        bit          lk_w   [5];
        logic [AB-1:0] ra;

        for (int a = 0; a < 4096; a++) begin
            ref_mem[a] = 32'h3C3C_0000 ^ 32'(a);
            csr_mem[a] = 32'h3C3C_0000 ^ 32'(a);
        end
        reset = 1'b1;
        req_valid = '0; req_rw = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0;
        csr_read_data_a = 32'h0; csr_read_data_b = 32'h0;

        // Reset state
        step();
        step();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_strobes", 64'({csr_read_enable, csr_write_enable}), 64'(0));
        reset = 1'b0;

        // Single read by requester 2
        ref_mem[12'h7C0] = 32'h1122_3344;
        csr_mem[12'h7C0] = 32'h1122_3344;
        set_req(2, 1'b1, 1'b0, 1'b0, 12'h7C0, 32'h0);
        step();
        chk("rd_strobe_t1", 64'(csr_read_enable), 64'(1));
        chk("rd_addr_t1", 64'(csr_read_addr), 64'(12'h7C0));
        clear_reqs();
        step();
        chk("rd_rsp_valid_t2", 64'(rsp_valid), 64'(1));
        chk("rd_rsp_idx_t2", 64'(rsp_idx), 64'(2));
        chk("rd_data_a_t2", 64'(rsp_data_a), 64'(32'h1122_3344));
        chk("rd_data_b_t2", 64'(rsp_data_b), 64'(32'h5566_7788));

        // Fairness: all four valid for 8 cycles after reset
        do_reset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'b1, 1'b0, 1'b0, 12'h7C0 + 12'(4 * i), 32'h0);
            step();
            chk("fair_grant", 64'(seen_ready), 64'(4'b0001 << (k % 4)));
        end
        clear_reqs();
        step();
        step();

        // Requester 1 writes then reads back
        set_req(1, 1'b1, 1'b1, 1'b0, 12'h7C4, 32'hDEAD_BEEF);
        step();
        chk("wr_strobe", 64'({csr_write_enable, csr_read_enable}), 64'(2'b10));
        chk("wr_addr_7c4", 64'(csr_write_addr), 64'(12'h7C4));
        chk("wr_data_beef", 64'(csr_write_data), 64'(32'hDEAD_BEEF));
        set_req(1, 1'b1, 1'b0, 1'b0, 12'h7C4, 32'h0);
        step();
        chk("rd_after_wr", 64'({csr_write_enable, csr_read_enable}), 64'(2'b01));
        clear_reqs();
        step();
        chk("wr_rd_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("wr_rd_rsp_idx", 64'(rsp_idx), 64'(1));
        chk("wr_rd_rsp_data", 64'(rsp_data_a), 64'(32'hDEAD_BEEF));

        // Lock sequence from requester 0 with one idle gap; 1..3 always valid
        lk_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        lk_l = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        lk_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef TCU_CSR_ARB_LOCK_EN
        lk_exp = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0010};
`else
        lk_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
`endif
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_req(0, lk_v[k], lk_w[k], lk_l[k], 12'h7D0 + 12'(4 * k), 32'hA000_0000 + 32'(k));
            for (int i = 1; i < N; i++)
                set_req(i, 1'b1, 1'b0, 1'b0, 12'h7C0 + 12'(4 * i), 32'h0);
            step();
            chk("lock_grant", 64'(seen_ready), 64'(lk_exp[k]));
        end
        clear_reqs();
        step();
        step();

        // Reset asserted the cycle after a read handshake
        set_req(3, 1'b1, 1'b0, 1'b0, 12'h7C8, 32'h0);
        step();
        step();
        set_req(0, 1'b1, 1'b0, 1'b0, 12'h7CC, 32'h0);
        step();
        clear_reqs();
        reset = 1'b1;
        step();
        chk("rst_drop_rsp", 64'(rsp_valid), 64'(0));
        reset = 1'b0;
        step();
        chk("rst_drop_rsp2", 64'(rsp_valid), 64'(0));
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 1'b0, 1'b0, 12'h7C0 + 12'(4 * i), 32'h0);
        step();
        chk("rst_ptr_zero", 64'(seen_ready), 64'(4'b0001));
        clear_reqs();
        step();
        step();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                ra = 12'h7C0 + 12'(4 * $urandom_range(0, 7));
                set_req(i, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0), ra, $urandom);
            end
            reset = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 1'b0;
        clear_reqs();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
